// File: rtl/alu_if_pkg.sv
// Shared definitions for the ALU/UART bridge: FSM encoding, opcode width and
// the opcode constants the external ALU decodes.
package alu_if_pkg;

    localparam int unsigned OP_W = 4;

    typedef enum logic [2:0] {
        StGetA,
        StGetB,
        StGetOp,
        StExec,
        StWaitRes,
        StWaitFlag
    } state_e;

    localparam logic [OP_W-1:0] OpAnd = 4'b0000;
    localparam logic [OP_W-1:0] OpOr  = 4'b0001;
    localparam logic [OP_W-1:0] OpAdd = 4'b0010;
    localparam logic [OP_W-1:0] OpSub = 4'b0110;
    localparam logic [OP_W-1:0] OpSlt = 4'b0111;
    localparam logic [OP_W-1:0] OpNor = 4'b1100;

endpackage

// File: rtl/alu_uart_if_if.sv
// Bundle of UART-side and ALU-side signals around the bridge.
// slave is the bridge's view; master is the surrounding UART/ALU.
interface alu_uart_if_if #(
    parameter int unsigned bits = 8
);
    logic [bits-1:0]               rx_data;
    logic                          rx_done;
    logic [bits-1:0]               alu_result;
    logic                          alu_zero;
    logic                          tx_done;
    logic [bits-1:0]               alu_a;
    logic [bits-1:0]               alu_b;
    logic [alu_if_pkg::OP_W-1:0]   alu_op;
    logic [bits-1:0]               tx_data;
    logic                          tx_start;
    logic                          busy;
    logic                          timeout_err;

    modport slave (
        input  rx_data, rx_done, alu_result, alu_zero, tx_done,
        output alu_a, alu_b, alu_op, tx_data, tx_start, busy, timeout_err
    );

    modport master (
        output rx_data, rx_done, alu_result, alu_zero, tx_done,
        input  alu_a, alu_b, alu_op, tx_data, tx_start, busy, timeout_err
    );
endinterface

// File: rtl/inactivity_timer.sv
// Idle-cycle counter: raises expired_o while enabled and the count sits at
// TIMEOUT-1; clear_i wins over counting.
module inactivity_timer #(
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expired_o = enable_i && (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/alu_uart_if.sv
// Collects A, B and opcode bytes from the UART, presents them to an external
// ALU, then sends back the result byte followed by the zero-flag byte.
module alu_uart_if
    import alu_if_pkg::*;
#(
    parameter int unsigned bits    = 8,
    parameter int unsigned TIMEOUT = 1000000
) (
    input logic          clk,
    input logic          rst_n,
    alu_uart_if_if.slave bus
);
    state_e            state_q, state_d;
    logic [bits-1:0]   alu_a_q, alu_a_d;
    logic [bits-1:0]   alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [bits-1:0]   tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              zero_q, zero_d;
    logic              rx_accept;
    logic              tmr_clear;
    logic              tmr_enable;
    logic              tmr_expired;

    assign tmr_enable = (state_q == StGetB) || (state_q == StGetOp);
    assign tmr_clear  = rx_accept || ((state_d == StGetA) && (state_q != StGetA));

    inactivity_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (tmr_clear),
        .enable_i (tmr_enable),
        .expired_o(tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        tx_data_d  = tx_data_q;
        zero_d     = zero_q;
        tx_start_d = 1'b0;
        rx_accept  = 1'b0;
        case (state_q)
            StGetA: begin
                if (bus.rx_done) begin
                    alu_a_d   = bus.rx_data;
                    rx_accept = 1'b1;
                    state_d   = StGetB;
                end
            end
            StGetB: begin
                // A byte landing on the terminal count still counts as on time.
                if (bus.rx_done) begin
                    alu_b_d   = bus.rx_data;
                    rx_accept = 1'b1;
                    state_d   = StGetOp;
                end else if (tmr_expired) begin
                    state_d = StGetA;
                end
            end
            StGetOp: begin
                if (bus.rx_done) begin
                    alu_op_d  = bus.rx_data[OP_W-1:0];
                    rx_accept = 1'b1;
                    state_d   = StExec;
                end else if (tmr_expired) begin
                    state_d = StGetA;
                end
            end
            StExec: begin
                tx_data_d  = bus.alu_result;
                zero_d     = bus.alu_zero;
                tx_start_d = 1'b1;
                state_d    = StWaitRes;
            end
            StWaitRes: begin
                if (bus.tx_done) begin
                    tx_data_d    = '0;
                    tx_data_d[0] = zero_q;
                    tx_start_d   = 1'b1;
                    state_d      = StWaitFlag;
                end
            end
            StWaitFlag: begin
                if (bus.tx_done) begin
                    state_d = StGetA;
                end
            end
            default: state_d = StGetA;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StGetA;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            zero_q     <= zero_d;
        end
    end

    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.busy        = (state_q != StGetA);
    assign bus.timeout_err = tmr_expired && !bus.rx_done;
endmodule

// File: tb/tb_alu_uart_if.sv
// Directed bench for alu_uart_if with a small behavioural ALU on the bus.
module tb_alu_uart_if;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_uart_if_if #(.bits(8)) bus ();

    alu_uart_if #(
        .bits   (8),
        .TIMEOUT(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU standing in for the external one.
    logic [7:0] alu_r;
    always_comb begin
        alu_r = 8'h00;
        case (bus.alu_op)
            4'b0000: alu_r = bus.alu_a & bus.alu_b;
            4'b0001: alu_r = bus.alu_a | bus.alu_b;
            4'b0010: alu_r = bus.alu_a + bus.alu_b;
            4'b0110: alu_r = bus.alu_a - bus.alu_b;
            4'b0111: alu_r = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 8'h01 : 8'h00;
            4'b1100: alu_r = ~(bus.alu_a | bus.alu_b);
            default: alu_r = 8'h00;
        endcase
        bus.alu_result = alu_r;
        bus.alu_zero   = (alu_r == 8'h00);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        tick();
        bus.rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
    endtask

    // Called right after the op byte was sampled (FSM in EXEC).
    task automatic expect_reply(input string tag, input logic [7:0] res, input logic [7:0] flag);
        chk({tag, "_exec_no_start"}, 32'(bus.tx_start), 32'd0);
        tick();
        chk({tag, "_res_start"}, 32'(bus.tx_start), 32'd1);
        chk({tag, "_res_data"}, 32'(bus.tx_data), 32'(res));
        tick();
        chk({tag, "_res_start_one_cycle"}, 32'(bus.tx_start), 32'd0);
        pulse_tx_done();
        chk({tag, "_flag_start"}, 32'(bus.tx_start), 32'd1);
        chk({tag, "_flag_data"}, 32'(bus.tx_data), 32'(flag));
        tick();
        pulse_tx_done();
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic seen;
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        bus.rx_data = 8'h00;
        bus.rx_done = 1'b0;
        bus.tx_done = 1'b0;
        repeat (2) tick();
        chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
        chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_timeout", 32'(bus.timeout_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // tx_done while idle must be ignored
        pulse_tx_done();
        chk("txdone_idle_ignored", 32'(bus.busy), 32'd0);

        // 5 + 3 = 8
        send_byte(8'h05);
        chk("a_loaded", 32'(bus.alu_a), 32'h05);
        chk("busy_in_get_b", 32'(bus.busy), 32'd1);
        send_byte(8'h03);
        send_byte(8'h02);
        chk("add_op", 32'(bus.alu_op), 32'h2);
        expect_reply("add", 8'h08, 8'h00);

        // 7 - 7 = 0 -> zero flag set
        send_byte(8'h07);
        send_byte(8'h07);
        send_byte(8'h06);
        expect_reply("sub", 8'h00, 8'h01);

        // Upper op bits ignored; rx strobes in WAIT_RES dropped
        send_byte(8'h09);
        send_byte(8'h04);
        send_byte(8'hF2);
        chk("op_upper_ignored", 32'(bus.alu_op), 32'h2);
        tick();
        chk("f2_res_data", 32'(bus.tx_data), 32'h0D);
        send_byte(8'hAA);
        send_byte(8'h55);
        chk("drop_alu_a", 32'(bus.alu_a), 32'h09);
        chk("drop_alu_b", 32'(bus.alu_b), 32'h04);
        chk("drop_tx_data", 32'(bus.tx_data), 32'h0D);
        chk("drop_no_start", 32'(bus.tx_start), 32'd0);
        chk("drop_still_busy", 32'(bus.busy), 32'd1);
        pulse_tx_done();
        chk("f2_flag_data", 32'(bus.tx_data), 32'h00);
        tick();
        pulse_tx_done();
        chk("f2_idle", 32'(bus.busy), 32'd0);

        // Timeout: A byte then silence; err 16 cycles after rx_done cycle
        send_byte(8'h05);
        seen = 1'b0;
        repeat (14) begin
            tick();
            if (bus.timeout_err) seen = 1'b1;
        end
        chk("no_early_timeout", 32'(seen), 32'd0);
        tick();
        chk("timeout_pulse", 32'(bus.timeout_err), 32'd1);
        tick();
        chk("timeout_one_cycle", 32'(bus.timeout_err), 32'd0);
        chk("timeout_to_get_a", 32'(bus.busy), 32'd0);
        chk("timeout_hold_a", 32'(bus.alu_a), 32'h05);
        chk("timeout_hold_b", 32'(bus.alu_b), 32'h04);
        send_byte(8'h0C);
        send_byte(8'h0A);
        send_byte(8'h00);
        expect_reply("and", 8'h08, 8'h00);

        // rx_done exactly at terminal count in GET_B is accepted
        send_byte(8'h01);
        repeat (15) tick();
        bus.rx_data = 8'h02;
        bus.rx_done = 1'b1;
        #1;
        chk("tc_no_timeout", 32'(bus.timeout_err), 32'd0);
        @(posedge clk);
        #1;
        bus.rx_done = 1'b0;
        chk("tc_b_accepted", 32'(bus.alu_b), 32'h02);
        chk("tc_still_busy", 32'(bus.busy), 32'd1);
        send_byte(8'h06);
        expect_reply("tc_sub", 8'hFF, 8'h00);

        // Reset during WAIT_RES aborts without a flag transmission
        send_byte(8'h03);
        send_byte(8'h01);
        send_byte(8'h02);
        tick();
        chk("pre_rst_data", 32'(bus.tx_data), 32'h04);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_alu_a", 32'(bus.alu_a), 32'd0);
        chk("mid_rst_alu_b", 32'(bus.alu_b), 32'd0);
        chk("mid_rst_alu_op", 32'(bus.alu_op), 32'd0);
        chk("mid_rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        bus.tx_done = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            tick();
            if (bus.tx_start) seen = 1'b1;
        end
        bus.tx_done = 1'b0;
        rst_n = 1'b1;
        tick();
        if (bus.tx_start) seen = 1'b1;
        chk("rst_no_tx_start", 32'(seen), 32'd0);
        chk("post_rst_idle", 32'(bus.busy), 32'd0);
        send_byte(8'h05);
        send_byte(8'h0A);
        send_byte(8'h01);
        expect_reply("post_rst_or", 8'h0F, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
